// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame scheduler for IMU sample -> physics step -> LED refresh.
// A free-running frame timer produces a tick. Each tick taken while idle and enabled
// runs the three stages in order: each stage gets a one-cycle start pulse, then the
// sequencer waits for that stage's done pulse, bounded by a per-stage timeout.
//
// state | meaning
// IDLE  | waiting for an enabled frame tick
// IMU   | imu_start issued, waiting for imu_done
// PHYS  | phys_step issued, waiting for phys_done
// LED   | led_start issued, waiting for led_done
module frame_sequencer #(
  parameter int FRAME_CYCLES   = 500_000,
  parameter int TIMEOUT_CYCLES = 65_536,
  parameter int FCNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear_err,
  output logic              imu_start,
  input  logic              imu_done,
  output logic              phys_step,
  input  logic              phys_done,
  output logic              led_start,
  input  logic              led_done,
  output logic [1:0]        stage,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_count,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int TMR_W = $clog2(FRAME_CYCLES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  // Both timers count down; terminal count is zero. A reset frame timer holds
  // FRAME_CYCLES-1, i.e. zero elapsed cycles into the frame.
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(FRAME_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_IMU  = 2'd1,
    S_PHYS = 2'd2,
    S_LED  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic               imu_start_q, imu_start_d;
  logic               phys_step_q, phys_step_d;
  logic               led_start_q, led_start_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;
  logic               tick;
  logic               start_cycle;
  logic               stage_done;
  logic               to_set;

  // Next-state: frame timer, stage sequencing, timeout counter and sticky flags.
  always_comb begin
    tick        = (tmr_q == '0);
    tmr_d       = tick ? TMR_LOAD : tmr_q - 1'b1;
    state_d     = state_q;
    to_d        = to_q;
    fcnt_d      = fcnt_q;
    imu_start_d = 1'b0;
    phys_step_d = 1'b0;
    led_start_d = 1'b0;
    to_set      = 1'b0;
    // The start pulse marks the first cycle of a stage; done is not sampled then.
    start_cycle = imu_start_q | phys_step_q | led_start_q;

    unique case (state_q)
      S_IMU:   stage_done = imu_done;
      S_PHYS:  stage_done = phys_done;
      S_LED:   stage_done = led_done;
      default: stage_done = 1'b0;
    endcase

    if (state_q == S_IDLE) begin
      if (tick && enable) begin
        state_d     = S_IMU;
        imu_start_d = 1'b1;
        to_d        = TO_LOAD;
      end
    end else if (!start_cycle && stage_done) begin
      to_d = TO_LOAD;
      unique case (state_q)
        S_IMU: begin
          state_d     = S_PHYS;
          phys_step_d = 1'b1;
        end
        S_PHYS: begin
          state_d     = S_LED;
          led_start_d = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          fcnt_d  = fcnt_q + 1'b1;
          to_d    = '0;
        end
      endcase
    end else if (to_q == '0) begin
      // Stage waited TIMEOUT_CYCLES without a done: abandon the frame.
      state_d = S_IDLE;
      to_set  = 1'b1;
    end else begin
      to_d = to_q - 1'b1;
    end

    // A tick while any stage is active (including the LED->IDLE cycle) is dropped.
    overrun_d = (tick && state_q != S_IDLE) || (overrun_q && !clear_err);
    timeout_d = to_set || (timeout_q && !clear_err);
    busy_d    = (state_d != S_IDLE);
  end

  // State and registered outputs; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tmr_q       <= TMR_LOAD;
      to_q        <= '0;
      fcnt_q      <= '0;
      imu_start_q <= 1'b0;
      phys_step_q <= 1'b0;
      led_start_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      to_q        <= to_d;
      fcnt_q      <= fcnt_d;
      imu_start_q <= imu_start_d;
      phys_step_q <= phys_step_d;
      led_start_q <= led_start_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stage       = state_q;
  assign busy        = busy_q;
  assign imu_start   = imu_start_q;
  assign phys_step   = phys_step_q;
  assign led_start   = led_start_q;
  assign frame_count = fcnt_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule
